regs_scoreboard: RTL and testbench
==================================

Name: regs_scoreboard

Overview:
- Issue-stage interlock controller for the 32x32 register file (two async read ports, one write port, r0 hardwired to zero, same-cycle write-to-read forwarding).
- Tracks which architectural registers have a write in flight and stalls issue on RAW and WAW hazards until writeback.
- Clears each pending entry on the writeback that drives the register file write port.
- Provides flush, status outputs and a saturating stall counter.

Parameters:
- MAX_INFLIGHT, 8, maximum simultaneously pending destination registers (1..31).
- STALL_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- issue_valid  input  1  instruction presented for issue this cycle.
- issue_rs1  input  5  first source register number.
- issue_rs2  input  5  second source register number.
- issue_use_rs1  input  1  instruction reads rs1.
- issue_use_rs2  input  1  instruction reads rs2.
- issue_rd  input  5  destination register number.
- issue_wr  input  1  instruction writes rd.
- issue_stall  output  1  combinational; instruction must be held this cycle.
- wb_valid  input  1  writeback to the register file this cycle.
- wb_rd  input  5  writeback destination register.
- flush  input  1  pipeline flush; discards all in-flight writes.
- pending  output  32  registered pending bit per register; bit 0 always 0.
- busy  output  1  registered; 1 when any pending bit is set.
- wb_err  output  1  sticky; writeback seen to a non-pending nonzero register.
- stall_count  output  STALL_W  saturating count of stalled issue cycles.

Behaviour:
- Reset (synchronous, highest priority): pending=0, inflight=0, busy=0, wb_err=0, stall_count=0.
- Effective pending is pending with the bit for wb_rd masked when wb_valid=1. This relies on register-file forwarding of same-cycle write data.
- issue_stall = issue_valid AND any of:
  - issue_use_rs1, rs1!=0 and effective pending[rs1];
  - issue_use_rs2, rs2!=0 and effective pending[rs2];
  - issue_wr, rd!=0 and effective pending[rd] (WAW);
  - issue_wr, rd!=0 and inflight==MAX_INFLIGHT, with no pending bit being cleared this cycle.
- issue_stall is 0 whenever issue_valid=0. rd=0 never stalls or sets state.
- fire = issue_valid AND NOT issue_stall.
- Next-state per cycle, applied in order:
  - If wb_valid and wb_rd!=0, clear pending[wb_rd].
  - If fire and issue_wr and rd!=0, set pending[rd].
  - Set wins over clear for the same register in the same cycle.
- inflight (internal, 0..MAX_INFLIGHT):
  - +1 on a set;
  - -1 on a clear of a bit that was actually 1;
  - unchanged when both occur.
  - Never exceeds MAX_INFLIGHT and never underflows.
- Writeback with wb_rd!=0 whose pending bit is 0: no state change, wb_err<=1 (sticky until reset). Writeback with wb_rd=0 is ignored silently.
- flush: next cycle pending=0, inflight=0, overriding same-cycle wb and issue updates. issue_stall is still driven combinationally. wb_err and stall_count are unaffected.
- stall_count increments by 1 on each cycle with issue_stall=1 and saturates at 2^STALL_W-1. It is not cleared by flush.
- busy = (next pending != 0), registered with pending.
- Latency: a set is visible on pending/busy one cycle after fire. A same-cycle writeback unblocks the dependent issue in that cycle (zero-latency release).
- Reset asserted mid-operation: all state cleared the following edge regardless of other inputs.

Test Plan:
- Reset: reset=1 for 2 cycles with random inputs -> pending=0, busy=0, wb_err=0, stall_count=0, issue_stall follows only combinational rules on the cleared state.
- RAW stall and release:
  - issue rd=5 wr=1 -> next cycle pending=0x20, busy=1;
  - issue rs1=5 use_rs1=1 -> issue_stall=1 for 3 cycles, stall_count=3;
  - wb_valid=1 wb_rd=5 in the same cycle as the held issue -> issue_stall=0 that cycle, pending=0 next.
- WAW and simultaneous set/clear: pending[7]=1; same cycle wb_rd=7 and issue rd=7 wr=1 -> no stall, pending[7] stays 1, inflight unchanged.
- r0 handling: issue rd=0 wr=1 then rs1=0 use_rs1=1 -> never stalls, pending stays 0. wb_rd=0 -> wb_err stays 0.
- Capacity: MAX_INFLIGHT=8, issue rd=1..8 -> ninth issue rd=9 stalls. Same cycle wb_rd=3 -> ninth issues, pending = bits 1,2,4..9.
- Flush and error:
  - pending=0x1E, flush=1 with issue rd=10 -> pending=0, busy=0 next cycle;
  - wb_rd=12 with pending[12]=0 -> wb_err=1, held through later flush until reset.

Source files
------------

// File: rtl/regs_scoreboard.sv
// Issue-stage interlock for the 32x32 register file. Tracks destination
// registers with a write in flight and holds issue on RAW, WAW and capacity
// hazards until the matching writeback. A same-cycle writeback releases the
// dependent issue at once, because the register file forwards write data.
module regs_scoreboard #(
  parameter int MAX_INFLIGHT = 8,
  parameter int STALL_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rs1,
  input  logic [4:0]         issue_rs2,
  input  logic               issue_use_rs1,
  input  logic               issue_use_rs2,
  input  logic [4:0]         issue_rd,
  input  logic               issue_wr,
  output logic               issue_stall,
  input  logic               wb_valid,
  input  logic [4:0]         wb_rd,
  input  logic               flush,
  output logic [31:0]        pending,
  output logic               busy,
  output logic               wb_err,
  output logic [STALL_W-1:0] stall_count
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  // Increment the stall counter, holding it at all-ones.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    if (&v) return v;
    return v + STALL_W'(1);
  endfunction

  logic [31:0]        pending_p1;
  logic [CNT_W-1:0]   inflight_p1;
  logic               busy_p1;
  logic               wb_err_p1;
  logic [STALL_W-1:0] stall_cnt_p1;

  logic [31:0]        wb_mask;
  logic [31:0]        eff_pend;
  logic [31:0]        pend_nxt;
  logic [CNT_W-1:0]   inflight_nxt;
  logic               wb_nz;
  logic               clr_hit;
  logic               wb_miss;
  logic               rs1_haz;
  logic               rs2_haz;
  logic               waw_haz;
  logic               cap_haz;
  logic               stall;
  logic               do_set;

  // Stage p0: hazard detection against pending bits with this cycle's writeback masked off.
  always_comb begin
    wb_nz    = wb_valid && (wb_rd != 5'd0);
    wb_mask  = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    eff_pend = pending_p1 & ~wb_mask;
    clr_hit  = wb_nz && pending_p1[wb_rd];
    wb_miss  = wb_nz && !pending_p1[wb_rd];

    rs1_haz  = issue_use_rs1 && (issue_rs1 != 5'd0) && eff_pend[issue_rs1];
    rs2_haz  = issue_use_rs2 && (issue_rs2 != 5'd0) && eff_pend[issue_rs2];
    waw_haz  = issue_wr && (issue_rd != 5'd0) && eff_pend[issue_rd];
    cap_haz  = issue_wr && (issue_rd != 5'd0) && (inflight_p1 == MAX_CNT) && !clr_hit;

    stall    = issue_valid && (rs1_haz || rs2_haz || waw_haz || cap_haz);
    do_set   = issue_valid && !stall && issue_wr && (issue_rd != 5'd0);

    pend_nxt = pending_p1;
    if (clr_hit) pend_nxt[wb_rd] = 1'b0;
    if (do_set)  pend_nxt[issue_rd] = 1'b1;

    inflight_nxt = inflight_p1;
    if (do_set && !clr_hit)      inflight_nxt = inflight_p1 + CNT_W'(1);
    else if (clr_hit && !do_set) inflight_nxt = inflight_p1 - CNT_W'(1);

    if (flush) begin
      pend_nxt     = '0;
      inflight_nxt = '0;
    end
  end

  // Stage p1: scoreboard state, sticky error flag and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_p1   <= '0;
      inflight_p1  <= '0;
      busy_p1      <= 1'b0;
      wb_err_p1    <= 1'b0;
      stall_cnt_p1 <= '0;
    end else begin
      pending_p1  <= pend_nxt;
      inflight_p1 <= inflight_nxt;
      busy_p1     <= (pend_nxt != 32'd0);
      if (wb_miss) wb_err_p1 <= 1'b1;
      if (stall)   stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign issue_stall = stall;
  assign pending     = pending_p1;
  assign busy        = busy_p1;
  assign wb_err      = wb_err_p1;
  assign stall_count = stall_cnt_p1;

endmodule

// File: tb/tb_regs_scoreboard.sv
// Directed bench for regs_scoreboard: a set-of-registers model checked on
// every cycle, plus hand-computed expectations along the directed sequence.
module tb_regs_scoreboard;

  localparam int MAXF    = 8;
  localparam int SW      = 16;
  localparam int SAT_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [4:0]    issue_rs1, issue_rs2, issue_rd;
  logic          issue_use_rs1, issue_use_rs2, issue_wr;
  logic          issue_stall;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic          flush;
  logic [31:0]   pending;
  logic          busy;
  logic          wb_err;
  logic [SW-1:0] stall_count;

  regs_scoreboard #(.MAX_INFLIGHT(MAXF), .STALL_W(SW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .pending(pending), .busy(busy), .wb_err(wb_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: set of registers awaiting writeback, error flag, stall tally.
  bit mp[32];
  bit m_err;
  int m_sc;

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(mp[r]);
    return n;
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = mp[r];
    return v;
  endfunction

  function automatic bit m_waiting(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return mp[r] && !(wb_valid && wb_rd == r);
  endfunction

  function automatic bit m_stall();
    bit freeing;
    if (!issue_valid) return 1'b0;
    freeing = wb_valid && (wb_rd != 5'd0) && mp[wb_rd];
    if (issue_use_rs1 && m_waiting(issue_rs1)) return 1'b1;
    if (issue_use_rs2 && m_waiting(issue_rs2)) return 1'b1;
    if (issue_wr && issue_rd != 5'd0) begin
      if (m_waiting(issue_rd)) return 1'b1;
      if (m_count() == MAXF && !freeing) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit st;
    st = m_stall();
    if (reset) begin
      for (int r = 0; r < 32; r++) mp[r] = 1'b0;
      m_err = 1'b0;
      m_sc  = 0;
      chk_en = 1'b1;
    end else begin
      if (st && m_sc < SAT_MAX) m_sc++;
      if (wb_valid && wb_rd != 5'd0 && !mp[wb_rd]) m_err = 1'b1;
      if (flush) begin
        for (int r = 0; r < 32; r++) mp[r] = 1'b0;
      end else begin
        if (wb_valid && wb_rd != 5'd0) mp[wb_rd] = 1'b0;
        if (issue_valid && !st && issue_wr && issue_rd != 5'd0) mp[issue_rd] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_issue_stall", {31'd0, issue_stall}, {31'd0, m_stall()});
      check("m_pending", pending, m_vec());
      check("m_busy", {31'd0, busy}, {31'd0, (m_vec() != 32'd0)});
      check("m_wb_err", {31'd0, wb_err}, {31'd0, m_err});
      check("m_stall_count", {16'd0, stall_count}, 32'(m_sc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    issue_use_rs1 = 0; issue_use_rs2 = 0; issue_wr = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic rand_inputs();
    issue_valid = 1'($urandom); issue_rs1 = 5'($urandom); issue_rs2 = 5'($urandom);
    issue_rd = 5'($urandom); issue_use_rs1 = 1'($urandom); issue_use_rs2 = 1'($urandom);
    issue_wr = 1'($urandom); wb_valid = 1'($urandom); wb_rd = 5'($urandom);
    flush = 1'($urandom);
  endtask

  task automatic iss(input logic [4:0] rd, input logic wr, input logic [4:0] rs1,
                     input logic u1, input logic [4:0] rs2, input logic u2);
    issue_valid = 1; issue_rd = rd; issue_wr = wr;
    issue_rs1 = rs1; issue_use_rs1 = u1; issue_rs2 = rs2; issue_use_rs2 = u2;
  endtask

  initial begin
    // reset with random inputs
    reset = 1; rand_inputs(); tick();
    rand_inputs(); tick();
    reset = 0; idle(); #1;
    check("rst_pending", pending, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wb_err", {31'd0, wb_err}, 32'd0);
    check("rst_stall_count", {16'd0, stall_count}, 32'd0);

    // RAW stall and release
    iss(5, 1, 0, 0, 0, 0); #1;
    check("raw_set_stall", {31'd0, issue_stall}, 32'd0);
    tick();
    idle(); iss(0, 0, 5, 1, 0, 0); #1;
    check("raw_pending", pending, 32'h20);
    check("raw_busy", {31'd0, busy}, 32'd1);
    check("raw_stall", {31'd0, issue_stall}, 32'd1);
    tick(); tick(); #1;
    check("raw_count2", {16'd0, stall_count}, 32'd2);
    tick();
    wb_valid = 1; wb_rd = 5; #1;
    check("raw_release", {31'd0, issue_stall}, 32'd0);
    check("raw_count3", {16'd0, stall_count}, 32'd3);
    tick();
    idle(); #1;
    check("raw_cleared", pending, 32'h0);
    check("raw_not_busy", {31'd0, busy}, 32'd0);

    // WAW with simultaneous set and clear
    iss(7, 1, 0, 0, 0, 0); tick();
    idle(); wb_valid = 1; wb_rd = 7; iss(7, 1, 0, 0, 0, 0); #1;
    check("waw_swap_stall", {31'd0, issue_stall}, 32'd0);
    tick();
    idle(); #1;
    check("waw_pending", pending, 32'h80);
    wb_valid = 1; wb_rd = 7; tick();
    idle(); #1;
    check("waw_cleared", pending, 32'h0);

    // r0 handling
    iss(0, 1, 0, 0, 0, 0); #1;
    check("r0_wr_stall", {31'd0, issue_stall}, 32'd0);
    tick();
    idle(); iss(0, 0, 0, 1, 0, 1); #1;
    check("r0_rd_stall", {31'd0, issue_stall}, 32'd0);
    tick();
    idle(); wb_valid = 1; wb_rd = 0; tick();
    idle(); #1;
    check("r0_pending", pending, 32'h0);
    check("r0_wb_err", {31'd0, wb_err}, 32'd0);

    // capacity
    for (int i = 1; i <= 8; i++) begin
      idle(); iss(5'(i), 1, 0, 0, 0, 0); tick();
    end
    idle(); #1;
    check("cap_full_pending", pending, 32'h1FE);
    iss(9, 1, 0, 0, 0, 0); #1;
    check("cap_stall", {31'd0, issue_stall}, 32'd1);
    tick();
    wb_valid = 1; wb_rd = 3; #1;
    check("cap_release", {31'd0, issue_stall}, 32'd0);
    tick();
    idle(); #1;
    check("cap_pending", pending, 32'h3F6);
    iss(10, 1, 0, 0, 0, 0); #1;
    check("cap_still_full", {31'd0, issue_stall}, 32'd1);
    tick();
    idle(); flush = 1; tick();
    idle(); #1;
    check("cap_flushed", pending, 32'h0);

    // flush overriding an issue
    for (int i = 1; i <= 4; i++) begin
      idle(); iss(5'(i), 1, 0, 0, 0, 0); tick();
    end
    idle(); #1;
    check("fl_pending", pending, 32'h1E);
    flush = 1; iss(10, 1, 0, 0, 0, 0); #1;
    check("fl_issue_stall", {31'd0, issue_stall}, 32'd0);
    tick();
    idle(); #1;
    check("fl_pending0", pending, 32'h0);
    check("fl_busy0", {31'd0, busy}, 32'd0);
    check("fl_count_kept", {16'd0, stall_count}, 32'd5);

    // sticky writeback error
    wb_valid = 1; wb_rd = 12; tick();
    idle(); #1;
    check("err_set", {31'd0, wb_err}, 32'd1);
    flush = 1; tick();
    idle(); tick(); #1;
    check("err_after_flush", {31'd0, wb_err}, 32'd1);
    check("cnt_after_flush", {16'd0, stall_count}, 32'd5);

    // reset in mid-operation
    iss(13, 1, 0, 0, 0, 0); tick();
    idle(); #1;
    check("mid_pending", pending, 32'h2000);
    reset = 1; iss(14, 1, 0, 0, 0, 0); wb_valid = 1; wb_rd = 20; tick();
    reset = 0; idle(); #1;
    check("mid_rst_pending", pending, 32'h0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_err", {31'd0, wb_err}, 32'd0);
    check("mid_rst_count", {16'd0, stall_count}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
